bp_ptw_walker: RTL and testbench



---
 rtl/bp_ptw_walker.sv | 204 ++++++++++++++++++++
 tb/tb_bp_ptw_walker.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_ptw_walker.sv
// SV39 hardware page-table walker: services TLB misses, fills leaf entries into the TLB or raises page faults.
// Optional feature macro: BP_PTW_SUPERPAGE_EN enables level-2 (gigapage) and level-1 (megapage) leaves.
module bp_ptw_walker #(
    localparam int vtag_width_p    = 27,
    localparam int ptag_width_p    = 28,
    localparam int paddr_width_p   = 40,
    localparam int dword_width_gp  = 64,
    localparam int pt_levels_p     = 3,
    localparam int vpn_idx_width_p = 9,
    localparam int entry_width_lp  = ptag_width_p + 7
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic [ptag_width_p-1:0]   satp_ppn_i,

    input  logic                      miss_v_i,
    output logic                      ready_o,
    input  logic [vtag_width_p-1:0]   miss_vtag_i,
    input  logic                      miss_instr_i,
    input  logic                      miss_load_i,
    input  logic                      miss_store_i,

    output logic                      mem_req_v_o,
    input  logic                      mem_req_ready_i,
    output logic [paddr_width_p-1:0]  mem_req_paddr_o,
    input  logic                      mem_resp_v_i,
    input  logic [dword_width_gp-1:0] mem_resp_data_i,

    output logic                      w_v_o,
    output logic [vtag_width_p-1:0]   w_vtag_o,
    output logic [entry_width_lp-1:0] w_entry_o,

    output logic                      instr_page_fault_o,
    output logic                      load_page_fault_o,
    output logic                      store_page_fault_o,
    output logic                      busy_o
);

    localparam logic [2:0] E_IDLE  = 3'd0;
    localparam logic [2:0] E_SEND  = 3'd1;
    localparam logic [2:0] E_RECV  = 3'd2;
    localparam logic [2:0] E_WRITE = 3'd3;
    localparam logic [2:0] E_FAULT = 3'd4;
    localparam logic [2:0] E_DRAIN = 3'd5;

    logic [2:0]                r_state;
    logic [1:0]                r_level;
    logic [vtag_width_p-1:0]   r_vtag;
    logic [ptag_width_p-1:0]   r_ppn;
    logic                      r_instr;
    logic                      r_load;
    logic                      r_store;
    logic [entry_width_lp-1:0] r_entry;

    logic [ptag_width_p-1:0]    w_pte_ppn;
    logic                       w_pte_v, w_pte_r, w_pte_w, w_pte_x;
    logic                       w_pte_u, w_pte_a, w_pte_d;
    logic [vpn_idx_width_p-1:0] w_vpn;
    logic                       w_misaligned;
    logic [ptag_width_p-1:0]    w_fill_ptag;
    logic                       w_level_ok;
    logic                       w_gigapage;
    logic                       w_invalid;
    logic                       w_leaf;
    logic                       w_leaf_fault;
    logic                       w_req_fire;
    logic [entry_width_lp-1:0]  w_entry_next;
    logic                       w_unused;

    assign w_pte_ppn = mem_resp_data_i[10 +: ptag_width_p];
    assign w_pte_v   = mem_resp_data_i[0];
    assign w_pte_r   = mem_resp_data_i[1];
    assign w_pte_w   = mem_resp_data_i[2];
    assign w_pte_x   = mem_resp_data_i[3];
    assign w_pte_u   = mem_resp_data_i[4];
    assign w_pte_a   = mem_resp_data_i[6];
    assign w_pte_d   = mem_resp_data_i[7];

    // Global bit, RSW and the PPN bits beyond the physical tag play no part in the walk.
    assign w_unused = &{1'b0, mem_resp_data_i[dword_width_gp-1:10+ptag_width_p],
                        mem_resp_data_i[9:8], mem_resp_data_i[5]};

    always_comb begin
        case (r_level)
            2'd2:    w_vpn = r_vtag[2*vpn_idx_width_p +: vpn_idx_width_p];
            2'd1:    w_vpn = r_vtag[vpn_idx_width_p +: vpn_idx_width_p];
            default: w_vpn = r_vtag[0 +: vpn_idx_width_p];
        endcase
    end

    assign mem_req_paddr_o = {r_ppn, w_vpn, 3'b000};

    // Superpage leaves must be aligned; the fill tag takes its low bits from the virtual tag.
    always_comb begin
        w_misaligned = 1'b0;
        w_fill_ptag  = w_pte_ppn;
        case (r_level)
            2'd2: begin
                w_misaligned = |w_pte_ppn[0 +: 2*vpn_idx_width_p];
                w_fill_ptag  = {w_pte_ppn[ptag_width_p-1:2*vpn_idx_width_p],
                                r_vtag[0 +: 2*vpn_idx_width_p]};
            end
            2'd1: begin
                w_misaligned = |w_pte_ppn[0 +: vpn_idx_width_p];
                w_fill_ptag  = {w_pte_ppn[ptag_width_p-1:vpn_idx_width_p],
                                r_vtag[0 +: vpn_idx_width_p]};
            end
            default: ;
        endcase
    end

`ifdef BP_PTW_SUPERPAGE_EN
    assign w_level_ok = 1'b1;
    assign w_gigapage = (r_level == 2'd2);
`else
    assign w_level_ok = (r_level == 2'd0);
    assign w_gigapage = 1'b0;
`endif

    assign w_invalid    = ~w_pte_v | (w_pte_w & ~w_pte_r);
    assign w_leaf       = w_pte_r | w_pte_x;
    assign w_leaf_fault = ~w_level_ok | w_misaligned | ~w_pte_a | (r_store & ~w_pte_d);
    assign w_entry_next = {w_fill_ptag, w_gigapage, w_pte_a, w_pte_d, w_pte_u,
                           w_pte_x, w_pte_w, w_pte_r};
    assign w_req_fire   = mem_req_v_o & mem_req_ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= E_IDLE;
            r_level <= '0;
            r_vtag  <= '0;
            r_ppn   <= '0;
            r_instr <= 1'b0;
            r_load  <= 1'b0;
            r_store <= 1'b0;
            r_entry <= '0;
        end else begin
            case (r_state)
                E_IDLE: begin
                    if (miss_v_i && ready_o) begin
                        r_vtag  <= miss_vtag_i;
                        r_ppn   <= satp_ppn_i;
                        r_instr <= miss_instr_i;
                        r_load  <= miss_load_i;
                        r_store <= miss_store_i;
                        r_level <= 2'(pt_levels_p - 1);
                        r_state <= E_SEND;
                    end
                end
                E_SEND: begin
                    if (flush_i) begin
                        r_state <= w_req_fire ? E_DRAIN : E_IDLE;
                    end else if (w_req_fire) begin
                        r_state <= E_RECV;
                    end
                end
                E_RECV: begin
                    if (mem_resp_v_i) begin
                        if (flush_i) begin
                            r_state <= E_IDLE;
                        end else if (w_invalid) begin
                            r_state <= E_FAULT;
                        end else if (w_leaf) begin
                            if (w_leaf_fault) begin
                                r_state <= E_FAULT;
                            end else begin
                                r_entry <= w_entry_next;
                                r_state <= E_WRITE;
                            end
                        end else if (r_level == 2'd0) begin
                            r_state <= E_FAULT;
                        end else begin
                            r_level <= r_level - 2'd1;
                            r_ppn   <= w_pte_ppn;
                            r_state <= E_SEND;
                        end
                    end else if (flush_i) begin
                        // Request already accepted: its response must still be absorbed.
                        r_state <= E_DRAIN;
                    end
                end
                E_WRITE, E_FAULT: r_state <= E_IDLE;
                E_DRAIN: begin
                    if (mem_resp_v_i) begin
                        r_state <= E_IDLE;
                    end
                end
                default: r_state <= E_IDLE;
            endcase
        end
    end

    assign ready_o            = (r_state == E_IDLE) & ~flush_i;
    assign busy_o             = (r_state != E_IDLE);
    assign mem_req_v_o        = (r_state == E_SEND);
    assign w_v_o              = (r_state == E_WRITE) & ~flush_i;
    assign w_vtag_o           = r_vtag;
    assign w_entry_o          = r_entry;
    assign instr_page_fault_o = (r_state == E_FAULT) & ~flush_i & r_instr;
    assign load_page_fault_o  = (r_state == E_FAULT) & ~flush_i & r_load;
    assign store_page_fault_o = (r_state == E_FAULT) & ~flush_i & r_store;

endmodule

// File: tb/tb_bp_ptw_walker.sv
// Self-checking bench for bp_ptw_walker: table-driven page walks plus directed flush, stall and reset sequences.
`timescale 1ns/1ps
module tb_bp_ptw_walker;

    logic        clk_i;
    logic        reset_i;
    logic        flush_i;
    logic [27:0] satp_ppn_i;
    logic        miss_v_i;
    logic        ready_o;
    logic [26:0] miss_vtag_i;
    logic        miss_instr_i;
    logic        miss_load_i;
    logic        miss_store_i;
    logic        mem_req_v_o;
    logic        mem_req_ready_i;
    logic [39:0] mem_req_paddr_o;
    logic        mem_resp_v_i;
    logic [63:0] mem_resp_data_i;
    logic        w_v_o;
    logic [26:0] w_vtag_o;
    logic [34:0] w_entry_o;
    logic        instr_page_fault_o;
    logic        load_page_fault_o;
    logic        store_page_fault_o;
    logic        busy_o;

    int assertCount = 0;
    int failCount   = 0;

    bp_ptw_walker dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .flush_i            (flush_i),
        .satp_ppn_i         (satp_ppn_i),
        .miss_v_i           (miss_v_i),
        .ready_o            (ready_o),
        .miss_vtag_i        (miss_vtag_i),
        .miss_instr_i       (miss_instr_i),
        .miss_load_i        (miss_load_i),
        .miss_store_i       (miss_store_i),
        .mem_req_v_o        (mem_req_v_o),
        .mem_req_ready_i    (mem_req_ready_i),
        .mem_req_paddr_o    (mem_req_paddr_o),
        .mem_resp_v_i       (mem_resp_v_i),
        .mem_resp_data_i    (mem_resp_data_i),
        .w_v_o              (w_v_o),
        .w_vtag_o           (w_vtag_o),
        .w_entry_o          (w_entry_o),
        .instr_page_fault_o (instr_page_fault_o),
        .load_page_fault_o  (load_page_fault_o),
        .store_page_fault_o (store_page_fault_o),
        .busy_o             (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // One record describes a complete miss: PTEs served per read, expected addresses and outcome.
    // evBits is {store fault, load fault, instr fault, fill}.
    typedef struct {
        string            name;
        logic [27:0]      satp;
        logic [26:0]      vtag;
        int               accType;
        logic [2:0][63:0] pte;
        int               nReads;
        logic [2:0][39:0] addr;
        logic [3:0]       evBits;
        int               evCycle;
        logic [34:0]      entry;
        int               flushAt;
    } walkVec_t;

    walkVec_t vecs[12];

    function automatic walkVec_t mkVec(input string name, input logic [27:0] satp,
                                       input logic [26:0] vtag, input int accType,
                                       input logic [63:0] p0, input logic [63:0] p1,
                                       input logic [63:0] p2, input int nReads,
                                       input logic [39:0] a0, input logic [39:0] a1,
                                       input logic [39:0] a2, input logic [3:0] evBits,
                                       input int evCycle, input logic [34:0] entry,
                                       input int flushAt);
        walkVec_t v;
        v.name    = name;
        v.satp    = satp;
        v.vtag    = vtag;
        v.accType = accType;
        v.pte     = {p2, p1, p0};
        v.nReads  = nReads;
        v.addr    = {a2, a1, a0};
        v.evBits  = evBits;
        v.evCycle = evCycle;
        v.entry   = entry;
        v.flushAt = flushAt;
        return v;
    endfunction

    // Compares one observed value against its expected value and keeps the tallies.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        flush_i         = 1'b0;
        miss_v_i        = 1'b0;
        miss_instr_i    = 1'b0;
        miss_load_i     = 1'b0;
        miss_store_i    = 1'b0;
        mem_req_ready_i = 1'b1;
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = '0;
    endtask

    // Starts a miss at cycle 0 (driven on the negedge before the accepting posedge).
    task automatic startMiss(input logic [26:0] vtag, input logic [27:0] satp, input int accType);
        @(negedge clk_i);
        miss_v_i     = 1'b1;
        miss_vtag_i  = vtag;
        satp_ppn_i   = satp;
        miss_instr_i = (accType == 0);
        miss_load_i  = (accType == 1);
        miss_store_i = (accType == 2);
    endtask

    // Runs one table walk: serves each read the cycle after its handshake and records the first outcome.
    task automatic applyStimulus(input walkVec_t v);
        int          reads;
        int          evCyc;
        logic [3:0]  evBits;
        logic [3:0]  gotBits;
        logic [34:0] gotEntry;
        logic [26:0] gotVtag;
        logic        pending;
        logic [63:0] pendData;
        logic [1:0]  idx;
        reads    = 0;
        evCyc    = -1;
        evBits   = '0;
        gotEntry = '0;
        gotVtag  = '0;
        pending  = 1'b0;
        pendData = '0;
        mem_req_ready_i = 1'b1;
        startMiss(v.vtag, v.satp, v.accType);
        #1;
        checkOutput($sformatf("%s accept ready", v.name), 64'(ready_o), 64'd1);
        for (int cyc = 1; cyc <= 20 && evCyc < 0; cyc++) begin
            @(negedge clk_i);
            miss_v_i        = 1'b0;
            miss_instr_i    = 1'b0;
            miss_load_i     = 1'b0;
            miss_store_i    = 1'b0;
            miss_vtag_i     = '1;
            satp_ppn_i      = 28'hFFF_FFFF;
            flush_i         = (cyc == v.flushAt);
            mem_resp_v_i    = pending;
            mem_resp_data_i = pending ? pendData : 64'hDEAD_BEEF_DEAD_BEEF;
            pending         = 1'b0;
            #1;
            if (mem_req_v_o) begin
                if (reads < 3) begin
                    idx = reads[1:0];
                    checkOutput($sformatf("%s read%0d paddr", v.name, reads),
                                64'(mem_req_paddr_o), 64'(v.addr[idx]));
                end
                idx      = (reads < 3) ? reads[1:0] : 2'd2;
                pendData = v.pte[idx];
                pending  = 1'b1;
                reads++;
            end
            gotBits = {store_page_fault_o, load_page_fault_o, instr_page_fault_o, w_v_o};
            if (gotBits != 4'b0000) begin
                evCyc    = cyc;
                evBits   = gotBits;
                gotEntry = w_entry_o;
                gotVtag  = w_vtag_o;
            end
        end
        flush_i      = 1'b0;
        mem_resp_v_i = 1'b0;
        checkOutput($sformatf("%s read count", v.name), 64'(reads), 64'(v.nReads));
        checkOutput($sformatf("%s outcome cycle", v.name), 64'(evCyc), 64'(v.evCycle));
        checkOutput($sformatf("%s outcome kind", v.name), 64'(evBits), 64'(v.evBits));
        if (v.evBits[0]) begin
            checkOutput($sformatf("%s fill entry", v.name), 64'(gotEntry), 64'(v.entry));
            checkOutput($sformatf("%s fill vtag", v.name), 64'(gotVtag), 64'(v.vtag));
        end
        @(negedge clk_i);
        #1;
        checkOutput($sformatf("%s ready after", v.name), 64'({ready_o, busy_o}), 64'(2'b10));
        checkOutput($sformatf("%s quiet after", v.name),
                    64'({store_page_fault_o, load_page_fault_o, instr_page_fault_o, w_v_o}), 64'd0);
    endtask

    logic [63:0] P2_CHAIN;
    logic [63:0] P1_CHAIN;
    logic [39:0] A0;
    logic [39:0] A1;
    logic [39:0] A2;

    initial begin
        int       hs;
        logic     sawOut;
        logic [39:0] firstAddr;

        // Level-2 table entry points at PPN 0x80001 (bit 40 set to show upper PTE bits are ignored),
        // level-1 entry at PPN 0x80002. For vtag 0x0012345: VPN2=0, VPN1=0x91, VPN0=0x145.
        P2_CHAIN = 64'h0000_0100_2000_0401;
        P1_CHAIN = 64'h0000_0000_2000_0801;
        A0 = 40'h00_8000_0000;
        A1 = 40'h00_8000_1488;
        A2 = 40'h00_8000_2A28;

        vecs[0]  = mkVec("l0_load", 28'h80000, 27'h0012345, 1, P2_CHAIN, P1_CHAIN,
                         64'h26AF3443, 3, A0, A1, A2, 4'b0001, 7, 35'h4D5E6A1, -1);
`ifdef BP_PTW_SUPERPAGE_EN
        vecs[1]  = mkVec("giga_load", 28'h80000, 27'h4000123, 1, 64'h10000043, 64'h0, 64'h0,
                         1, 40'h00_8000_0800, 40'h0, 40'h0, 4'b0001, 3, 35'h20091E1, -1);
        vecs[5]  = mkVec("mega_instr", 28'h80000, 27'h0012345, 0, P2_CHAIN, 64'h20080049, 64'h0,
                         2, A0, A1, 40'h0, 4'b0001, 5, 35'h401A2A4, -1);
`else
        vecs[1]  = mkVec("giga_load", 28'h80000, 27'h4000123, 1, 64'h10000043, 64'h0, 64'h0,
                         1, 40'h00_8000_0800, 40'h0, 40'h0, 4'b0100, 3, 35'h0, -1);
        vecs[5]  = mkVec("mega_instr", 28'h80000, 27'h0012345, 0, P2_CHAIN, 64'h20080049, 64'h0,
                         2, A0, A1, 40'h0, 4'b0010, 5, 35'h0, -1);
`endif
        vecs[2]  = mkVec("store_d0", 28'h80000, 27'h0012345, 2, P2_CHAIN, P1_CHAIN,
                         64'h26AF3447, 3, A0, A1, A2, 4'b1000, 7, 35'h0, -1);
        vecs[3]  = mkVec("instr_invalid", 28'h80000, 27'h0012345, 0, 64'h26AF344E, 64'h0, 64'h0,
                         1, A0, 40'h0, 40'h0, 4'b0010, 3, 35'h0, -1);
        vecs[4]  = mkVec("store_d1", 28'h80000, 27'h0012345, 2, P2_CHAIN, P1_CHAIN,
                         64'h048D14C7, 3, A0, A1, A2, 4'b0001, 7, 35'h091A2B3, -1);
        vecs[6]  = mkVec("mega_misaligned", 28'h80000, 27'h0012345, 1, P2_CHAIN, 64'h20080443,
                         64'h0, 2, A0, A1, 40'h0, 4'b0100, 5, 35'h0, -1);
        vecs[7]  = mkVec("w_without_r", 28'h80000, 27'h0012345, 1, P2_CHAIN, 64'h20000805,
                         64'h0, 2, A0, A1, 40'h0, 4'b0100, 5, 35'h0, -1);
        vecs[8]  = mkVec("nonleaf_l0", 28'h80000, 27'h0012345, 1, P2_CHAIN, P1_CHAIN,
                         64'h26AF34C1, 3, A0, A1, A2, 4'b0100, 7, 35'h0, -1);
        vecs[9]  = mkVec("accessed_clear", 28'h80000, 27'h0012345, 1, P2_CHAIN, P1_CHAIN,
                         64'h26AF3403, 3, A0, A1, A2, 4'b0100, 7, 35'h0, -1);
        vecs[10] = mkVec("flush_on_fill", 28'h80000, 27'h0012345, 1, P2_CHAIN, P1_CHAIN,
                         64'h26AF3443, 3, A0, A1, A2, 4'b0000, -1, 35'h0, 7);
        vecs[11] = mkVec("flush_on_fault", 28'h80000, 27'h0012345, 2, P2_CHAIN, P1_CHAIN,
                         64'h26AF3447, 3, A0, A1, A2, 4'b0000, -1, 35'h0, 7);

        idleInputs();
        miss_vtag_i = '0;
        satp_ppn_i  = '0;
        reset_i     = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        checkOutput("reset ready/busy", 64'({ready_o, busy_o}), 64'(2'b10));
        checkOutput("reset mem req", 64'({mem_req_v_o, mem_req_paddr_o}), 64'd0);
        checkOutput("reset fill", 64'({w_v_o, w_vtag_o}), 64'd0);
        checkOutput("reset entry", 64'(w_entry_o), 64'd0);
        checkOutput("reset faults",
                    64'({instr_page_fault_o, load_page_fault_o, store_page_fault_o}), 64'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
        end

        // Flush while waiting for a response; the response shows up four cycles later and is dropped.
        idleInputs();
        sawOut = 1'b0;
        startMiss(27'h0012345, 28'h80000, 1);
        @(negedge clk_i);
        idleInputs();
        #1;
        checkOutput("flushRecv request", 64'(mem_req_v_o), 64'd1);
        @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        checkOutput("flushRecv ready in flush", 64'(ready_o), 64'd0);
        for (int cyc = 3; cyc <= 6; cyc++) begin
            @(negedge clk_i);
            flush_i         = 1'b0;
            mem_resp_v_i    = (cyc == 6);
            mem_resp_data_i = 64'h26AF3443;
            #1;
            checkOutput($sformatf("flushRecv drain c%0d", cyc),
                        64'({busy_o, ready_o, mem_req_v_o}), 64'(3'b100));
            sawOut = sawOut | w_v_o | instr_page_fault_o | load_page_fault_o | store_page_fault_o;
        end
        @(negedge clk_i);
        mem_resp_v_i = 1'b0;
        #1;
        checkOutput("flushRecv ready after resp", 64'(ready_o), 64'd1);
        sawOut = sawOut | w_v_o | instr_page_fault_o | load_page_fault_o | store_page_fault_o;
        checkOutput("flushRecv no output", 64'(sawOut), 64'd0);

        // Ready withheld for five cycles: the request must hold steady and handshake once.
        idleInputs();
        mem_req_ready_i = 1'b0;
        hs = 0;
        firstAddr = 40'h00_8000_0000;
        startMiss(27'h0012345, 28'h80000, 1);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk_i);
            miss_v_i        = 1'b0;
            miss_load_i     = 1'b0;
            satp_ppn_i      = 28'(cyc * 28'h1111);
            mem_req_ready_i = (cyc >= 6);
            mem_resp_v_i    = (cyc == 7);
            mem_resp_data_i = 64'h0;
            #1;
            if (cyc <= 6) begin
                checkOutput($sformatf("stall request c%0d", cyc),
                            64'({mem_req_v_o, mem_req_paddr_o}), {23'd0, 1'b1, firstAddr});
            end
            if (mem_req_v_o && mem_req_ready_i) hs++;
            if (cyc == 8) begin
                checkOutput("stall load fault", 64'(load_page_fault_o), 64'd1);
            end
        end
        mem_resp_v_i = 1'b0;
        checkOutput("stall handshakes", 64'(hs), 64'd1);
        @(negedge clk_i);
        #1;
        checkOutput("stall fault single pulse", 64'({load_page_fault_o, ready_o}), 64'(2'b01));

        // Flush coinciding with the request handshake: walker drains the reply.
        idleInputs();
        sawOut = 1'b0;
        startMiss(27'h0012345, 28'h80000, 1);
        @(negedge clk_i);
        idleInputs();
        flush_i = 1'b1;
        #1;
        checkOutput("flushSend req still valid", 64'(mem_req_v_o), 64'd1);
        @(negedge clk_i);
        flush_i         = 1'b0;
        mem_resp_v_i    = 1'b1;
        mem_resp_data_i = 64'h10000043;
        #1;
        checkOutput("flushSend draining", 64'({busy_o, ready_o}), 64'(2'b10));
        sawOut = sawOut | w_v_o | instr_page_fault_o | load_page_fault_o | store_page_fault_o;
        @(negedge clk_i);
        mem_resp_v_i = 1'b0;
        #1;
        sawOut = sawOut | w_v_o | instr_page_fault_o | load_page_fault_o | store_page_fault_o;
        checkOutput("flushSend idle after drain", 64'({busy_o, ready_o, sawOut}), 64'(3'b010));

        // Flush before the handshake drops the walk straight back to idle.
        idleInputs();
        mem_req_ready_i = 1'b0;
        startMiss(27'h0012345, 28'h80000, 1);
        @(negedge clk_i);
        idleInputs();
        mem_req_ready_i = 1'b0;
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        checkOutput("flushSend no hs idle", 64'({busy_o, ready_o, mem_req_v_o}), 64'(3'b010));

        // Flush in idle blocks acceptance of a simultaneous miss.
        idleInputs();
        startMiss(27'h0012345, 28'h80000, 1);
        flush_i = 1'b1;
        #1;
        checkOutput("flushIdle ready gated", 64'(ready_o), 64'd0);
        @(negedge clk_i);
        idleInputs();
        #1;
        checkOutput("flushIdle not accepted", 64'({busy_o, ready_o}), 64'(2'b01));

        // Reset in the middle of a walk returns everything to its reset state.
        idleInputs();
        startMiss(27'h0012345, 28'h80000, 1);
        @(negedge clk_i);
        idleInputs();
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        checkOutput("midReset state", 64'({busy_o, ready_o, mem_req_v_o}), 64'(3'b010));
        checkOutput("midReset latched", 64'({w_vtag_o, w_entry_o}), 64'd0);
        applyStimulus(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
